// File: rtl/bus_arb.sv
// bus_arb: round-robin arbiter that shares one upstream bus master port among NREQ requesters.
// Optional watchdog (TOUT state, timeout_flag port) is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arb #(
  parameter int NREQ           = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_core,
  input  logic                 reset,
  // requester side
  input  logic [NREQ-1:0]      req_cvalid,
  output logic [NREQ-1:0]      arb_cready,
  input  logic [NREQ-1:0]      req_cmd,
  input  logic [NREQ*27-1:0]   req_addr,
  input  logic [NREQ-1:0]      req_wvalid,
  output logic [NREQ-1:0]      arb_wready,
  input  logic [NREQ-1:0]      req_wlast,
  input  logic [NREQ*32-1:0]   req_wdata,
  input  logic [NREQ*4-1:0]    req_wmask,
  output logic [NREQ-1:0]      arb_rvalid,
  input  logic [NREQ-1:0]      req_rready,
  output logic                 arb_rlast,
  output logic [31:0]          arb_rdata,
  output logic [NREQ-1:0]      arb_error,
  input  logic [NREQ-1:0]      req_eack,
  // downstream bus side
  output logic                 arb_cvalid,
  output logic                 arb_cmd,
  output logic [26:0]          arb_addr,
  input  logic                 bus_cready,
  output logic                 arb_wvalid,
  output logic                 arb_wlast,
  output logic [31:0]          arb_wdata,
  output logic [3:0]           arb_wmask,
  input  logic                 bus_wready,
  input  logic                 bus_rvalid,
  input  logic                 bus_rlast,
  input  logic [31:0]          bus_rdata,
  output logic                 arb_rready,
  input  logic                 bus_error,
  output logic                 arb_eack,
  // status
  output logic [NREQ-1:0]      arb_grant,
`ifdef BUS_ARB_TIMEOUT_EN
  output logic                 timeout_flag,
`endif
  output logic [1:0]           arb_state
);

  // Handshakes: a beat transfers on a rising clk_core edge where valid and ready are both 1;
  // a source that raises valid holds it, with its payload stable, until that beat.

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef BUS_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, TOUT = 2'd3} state_t;
  localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tcnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;
  // The watchdog limit only matters in the timeout build.
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  state_t          state;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   last;
  logic            rd;

  // granted requester's channels
  int              gsel;
  logic            g_cvalid, g_cmd, g_wvalid, g_wlast, g_rready, g_eack;
  logic [26:0]     g_addr;
  logic [31:0]     g_wdata;
  logic [3:0]      g_wmask;

  assign gsel     = int'(gidx);
  assign g_cvalid = req_cvalid[gidx];
  assign g_cmd    = req_cmd[gidx];
  assign g_wvalid = req_wvalid[gidx];
  assign g_wlast  = req_wlast[gidx];
  assign g_rready = req_rready[gidx];
  assign g_eack   = req_eack[gidx];
  assign g_addr   = req_addr[gsel*27 +: 27];
  assign g_wdata  = req_wdata[gsel*32 +: 32];
  assign g_wmask  = req_wmask[gsel*4 +: 4];

  logic in_cmd, in_data, wr_ph, rd_ph, active;
  assign in_cmd  = (state == CMD);
  assign in_data = (state == DATA);
  assign wr_ph   = in_data & ~rd;
  assign rd_ph   = in_data & rd;
  assign active  = in_cmd | in_data;

  // Everything below is gated by registered state, so reset silences the bus immediately.
  assign arb_cvalid = in_cmd & g_cvalid;
  assign arb_cmd    = in_cmd & g_cmd;
  assign arb_addr   = in_cmd ? g_addr : 27'd0;
  assign arb_cready = in_cmd ? (grant & {NREQ{bus_cready}}) : '0;

  assign arb_wvalid = wr_ph & g_wvalid;
  assign arb_wlast  = wr_ph & g_wlast;
  assign arb_wdata  = wr_ph ? g_wdata : 32'd0;
  assign arb_wmask  = wr_ph ? g_wmask : 4'd0;
  assign arb_wready = wr_ph ? (grant & {NREQ{bus_wready}}) : '0;

  assign arb_rvalid = rd_ph ? (grant & {NREQ{bus_rvalid}}) : '0;
  assign arb_rready = rd_ph & g_rready;
  assign arb_rlast  = rd_ph & bus_rlast;
  assign arb_rdata  = rd_ph ? bus_rdata : 32'd0;

  assign arb_eack   = active & g_eack;

  always_comb begin
    arb_error = active ? (grant & {NREQ{bus_error}}) : '0;
`ifdef BUS_ARB_TIMEOUT_EN
    if (state == TOUT) arb_error = grant;
`endif
  end

  assign arb_grant = grant;
  assign arb_state = state;

  logic cmd_fire, w_fire, r_fire, txn_done;
  assign cmd_fire = arb_cvalid & bus_cready;
  assign w_fire   = arb_wvalid & bus_wready;
  assign r_fire   = bus_rvalid & arb_rready;
  assign txn_done = (bus_error & arb_eack) | (w_fire & g_wlast) | (r_fire & bus_rlast);

  // Round-robin search starting just after the last completed requester.
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;

  always_comb begin
    int idx;
    logic [IW-1:0] idx_t;
    idx        = 0;
    idx_t      = '0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_t = idx[IW-1:0];
      if (!pick_found && req_cvalid[idx_t]) begin
        pick_found     = 1'b1;
        pick_idx       = idx_t;
        pick_oh[idx_t] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= IW'(NREQ - 1);
      rd    <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      tcnt         <= 16'd0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_oh;
            gidx  <= pick_idx;
            state <= CMD;
`ifdef BUS_ARB_TIMEOUT_EN
            tcnt  <= 16'd0;
`endif
          end
        end
        CMD, DATA: begin
          if (txn_done) begin
            state <= IDLE;
            grant <= '0;
            last  <= gidx;
          end else if (cmd_fire) begin
            rd    <= g_cmd;
            state <= DATA;
`ifdef BUS_ARB_TIMEOUT_EN
            tcnt  <= 16'd0;
          end else if (w_fire || r_fire) begin
            tcnt <= 16'd0;
          end else if (tcnt == TOUT_LAST) begin
            state        <= TOUT;
            timeout_flag <= 1'b1;
          end else begin
            tcnt <= tcnt + 16'd1;
`endif
          end
        end
`ifdef BUS_ARB_TIMEOUT_EN
        TOUT: begin
          if (req_eack[gidx]) begin
            state <= IDLE;
            grant <= '0;
            last  <= gidx;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic [26:0] dbg_addr;
  always @(posedge clk_core) begin
    if (!reset) begin
      if (state == IDLE && pick_found) begin
        dbg_addr <= req_addr[int'(pick_idx)*27 +: 27];
        $display("bus_arb: grant req%0d addr=%h", pick_idx, req_addr[int'(pick_idx)*27 +: 27]);
      end
      if (active && txn_done)
        $display("bus_arb: done req%0d addr=%h", gidx, dbg_addr);
      if (in_cmd && !g_cvalid)
        $error("bus_arb: req%0d dropped cvalid before cready", gidx);
    end
  end
`endif

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb (NREQ=2): reset, read, contention, write burst, error, reset mid-read.
module tb_bus_arb;
  localparam int NREQ = 2;

  logic              clk_core = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_cvalid, arb_cready, req_cmd;
  logic [NREQ*27-1:0] req_addr;
  logic [NREQ-1:0]   req_wvalid, arb_wready, req_wlast;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ*4-1:0] req_wmask;
  logic [NREQ-1:0]   arb_rvalid, req_rready;
  logic              arb_rlast;
  logic [31:0]       arb_rdata;
  logic [NREQ-1:0]   arb_error, req_eack;
  logic              arb_cvalid, arb_cmd;
  logic [26:0]       arb_addr;
  logic              bus_cready;
  logic              arb_wvalid, arb_wlast;
  logic [31:0]       arb_wdata;
  logic [3:0]        arb_wmask;
  logic              bus_wready, bus_rvalid, bus_rlast;
  logic [31:0]       bus_rdata;
  logic              arb_rready, bus_error, arb_eack;
  logic [NREQ-1:0]   arb_grant;
  logic [1:0]        arb_state;
`ifdef BUS_ARB_TIMEOUT_EN
  logic              timeout_flag;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] wd [4];
  logic [3:0]  wm [4];

  always #5 clk_core = ~clk_core;

  bus_arb #(.NREQ(NREQ), .TIMEOUT_CYCLES(16)) dut (
    .clk_core(clk_core), .reset(reset),
    .req_cvalid(req_cvalid), .arb_cready(arb_cready), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wvalid(req_wvalid), .arb_wready(arb_wready), .req_wlast(req_wlast),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .arb_rvalid(arb_rvalid), .req_rready(req_rready), .arb_rlast(arb_rlast), .arb_rdata(arb_rdata),
    .arb_error(arb_error), .req_eack(req_eack),
    .arb_cvalid(arb_cvalid), .arb_cmd(arb_cmd), .arb_addr(arb_addr), .bus_cready(bus_cready),
    .arb_wvalid(arb_wvalid), .arb_wlast(arb_wlast), .arb_wdata(arb_wdata), .arb_wmask(arb_wmask),
    .bus_wready(bus_wready), .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_rdata(bus_rdata),
    .arb_rready(arb_rready), .bus_error(bus_error), .arb_eack(arb_eack),
    .arb_grant(arb_grant),
`ifdef BUS_ARB_TIMEOUT_EN
    .timeout_flag(timeout_flag),
`endif
    .arb_state(arb_state)
  );

  // Inputs change 1 ns after the rising edge; checks sample 1 ns later.
  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    req_cvalid = '0; req_cmd = '0; req_addr = '0;
    req_wvalid = '0; req_wlast = '0; req_wdata = '0; req_wmask = '0;
    req_rready = '0; req_eack = '0;
    bus_cready = 1'b0; bus_wready = 1'b0; bus_rvalid = 1'b0; bus_rlast = 1'b0;
    bus_rdata = '0; bus_error = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g;
    wd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    wm = '{4'b1111, 4'b0011, 4'b1100, 4'b1111};

    // reset: outputs quiet even with downstream read data present
    reset = 1'b1;
    zero_inputs();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEADBEEF;
    step(); step();
    #1;
    chk("rst_grant", arb_grant, 0);
    chk("rst_state", arb_state, 0);
    chk("rst_rdata", arb_rdata, 0);
    chk("rst_rvalid", arb_rvalid, 0);
    chk("rst_cready", arb_cready, 0);
    chk("rst_addr", arb_addr, 0);
    step();
    reset = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;

    // single read from req0
    step();
    req_cvalid = 2'b01;
    req_cmd    = 2'b01;
    req_addr[26:0]  = 27'h40;
    req_addr[53:27] = 27'h7FFFFFF;
    bus_cready = 1'b1;
    #1;
    chk("rd_idle_cready", arb_cready, 0);
    chk("rd_idle_grant", arb_grant, 0);
    step(); #1;
    chk("rd_grant", arb_grant, 2'b01);
    chk("rd_cvalid", arb_cvalid, 1);
    chk("rd_addr", arb_addr, 27'h40);
    chk("rd_cmd", arb_cmd, 1);
    chk("rd_cready", arb_cready, 2'b01);
    chk("rd_state_cmd", arb_state, 1);
    step();
    req_cvalid = '0; bus_cready = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 32'hAAAA5555; bus_rlast = 1'b0; req_rready = 2'b01;
    #1;
    chk("rd_b1_rvalid", arb_rvalid, 2'b01);
    chk("rd_b1_rdata", arb_rdata, 32'hAAAA5555);
    chk("rd_b1_rready", arb_rready, 1);
    chk("rd_b1_wvalid", arb_wvalid, 0);
    chk("rd_state_data", arb_state, 2);
    step();
    bus_rdata = 32'h12345678; bus_rlast = 1'b1;
    #1;
    chk("rd_b2_rdata", arb_rdata, 32'h12345678);
    chk("rd_b2_rlast", arb_rlast, 1);
    chk("rd_b2_grant", arb_grant, 2'b01);
    step();
    bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_rdata = '0; req_rready = '0;
    #1;
    chk("rd_done_grant", arb_grant, 0);
    chk("rd_done_state", arb_state, 0);

    // contention: last=0, so req1 wins first, then alternation
    req_cmd = 2'b11; bus_cready = 1'b1; req_rready = 2'b11; req_cvalid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      step(); #1;
      chk("rr_grant", arb_grant, exp_g);
      chk("rr_cready", arb_cready, exp_g);
      step();
      req_cvalid = 2'b11 & ~exp_g; bus_rvalid = 1'b1; bus_rlast = 1'b1;
      #1;
      chk("rr_rvalid", arb_rvalid, exp_g);
      step();
      bus_rvalid = 1'b0; bus_rlast = 1'b0; req_cvalid = 2'b11;
      #1;
      chk("rr_idle", arb_grant, 0);
    end

    // write burst from req1 with toggling bus_wready; req0 lanes carry junk
    req_cvalid = 2'b10; req_cmd = 2'b00; req_addr[53:27] = 27'h5A5A5A5;
    req_rready = '0; bus_cready = 1'b1;
    step(); #1;
    chk("wr_grant", arb_grant, 2'b10);
    chk("wr_addr", arb_addr, 27'h5A5A5A5);
    chk("wr_cmd", arb_cmd, 0);
    step();
    req_cvalid = '0; bus_cready = 1'b0; bus_rvalid = 1'b1;
    req_wvalid = 2'b11; req_wdata[31:0] = 32'hFFFFFFFF; req_wmask[3:0] = 4'b0101;
    for (int b = 0; b < 4; b++) begin
      req_wdata[63:32] = wd[b];
      req_wmask[7:4]   = wm[b];
      req_wlast        = {(b == 3), 1'b1};
      bus_wready       = 1'b0;
      #1;
      chk("wr_wdata", arb_wdata, wd[b]);
      chk("wr_wmask", arb_wmask, wm[b]);
      chk("wr_wready_lo", arb_wready, 0);
      chk("wr_rvalid_iso", arb_rvalid, 0);
      chk("wr_hold_grant", arb_grant, 2'b10);
      step();
      bus_wready = 1'b1;
      #1;
      chk("wr_wready_hi", arb_wready, 2'b10);
      chk("wr_wlast", arb_wlast, (b == 3));
      step();
    end
    req_wvalid = '0; req_wlast = '0; bus_wready = 1'b0; bus_rvalid = 1'b0;
    #1;
    chk("wr_done_grant", arb_grant, 0);

    // error on req0 read, acknowledged three cycles later; req1 pending
    req_cvalid = 2'b11; req_cmd = 2'b01; req_addr[26:0] = 27'h100; bus_cready = 1'b1;
    step(); #1;
    chk("er_grant", arb_grant, 2'b01);
    step();
    req_cvalid = 2'b10; bus_cready = 1'b0; bus_error = 1'b1;
    #1;
    chk("er_error", arb_error, 2'b01);
    chk("er_eack_lo", arb_eack, 0);
    repeat (2) begin
      step(); #1;
      chk("er_hold", arb_error, 2'b01);
      chk("er_hold_grant", arb_grant, 2'b01);
    end
    step();
    req_eack = 2'b01;
    #1;
    chk("er_eack_hi", arb_eack, 1);
    step();
    bus_error = 1'b0; req_eack = '0;
    #1;
    chk("er_done_grant", arb_grant, 0);
    chk("er_done_error", arb_error, 0);
    step();
    bus_cready = 1'b1;
    #1;
    chk("er_next_grant", arb_grant, 2'b10);
    chk("er_next_cready", arb_cready, 2'b10);
    step();
    req_cvalid = '0; bus_cready = 1'b0;
    req_wvalid = 2'b10; req_wlast = 2'b10; req_wdata[63:32] = 32'hCAFEF00D; bus_wready = 1'b1;
    #1;
    chk("er_next_wdata", arb_wdata, 32'hCAFEF00D);
    step();
    req_wvalid = '0; req_wlast = '0; bus_wready = 1'b0;
    #1;
    chk("er_next_done", arb_grant, 0);

    // req0 completes (last=0), then reset aborts a req1 read
    req_cvalid = 2'b01; req_cmd = 2'b11; bus_cready = 1'b1;
    step(); #1;
    chk("rs_grant0", arb_grant, 2'b01);
    step();
    req_cvalid = '0; bus_cready = 1'b0; bus_rvalid = 1'b1; bus_rlast = 1'b1;
    req_rready = 2'b11; bus_rdata = 32'h55;
    step();
    bus_rvalid = 1'b0; bus_rlast = 1'b0;
    #1;
    chk("rs_idle", arb_grant, 0);
    req_cvalid = 2'b10; bus_cready = 1'b1;
    step(); #1;
    chk("rs_grant1", arb_grant, 2'b10);
    step();
    req_cvalid = '0; bus_cready = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h77;
    #1;
    chk("rs_rready_pre", arb_rready, 1);
    chk("rs_rvalid_pre", arb_rvalid, 2'b10);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_rready", arb_rready, 0);
    chk("rs_rvalid", arb_rvalid, 0);
    chk("rs_grant", arb_grant, 0);
    chk("rs_rdata", arb_rdata, 0);
    chk("rs_state", arb_state, 0);
    step();
    reset = 1'b0; bus_rvalid = 1'b0; req_cvalid = 2'b11;
    #1;
    chk("rs_idle_cready", arb_cready, 0);
    step(); #1;
    chk("rs_first_grant", arb_grant, 2'b01);

`ifdef BUS_ARB_TIMEOUT_EN
    // slave never accepts the command: TOUT 16 cycles after entering CMD
    repeat (15) step();
    #1;
    chk("to_before", arb_error, 0);
    chk("to_flag_before", timeout_flag, 0);
    step(); #1;
    chk("to_error", arb_error, 2'b01);
    chk("to_flag", timeout_flag, 1);
    chk("to_cvalid", arb_cvalid, 0);
    req_cvalid = '0; req_eack = 2'b01;
    step(); #1;
    chk("to_idle", arb_state, 0);
    chk("to_flag_sticky", timeout_flag, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
